// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status, Cause, EPC, BadVAddr, Count, Compare.
// Optional timer match logic via `CP0_TIMER_INT_EN.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   we_i/waddr_i/data_i    MTC0 write
//   raddr_i/data_o         MFC0 read (combinational, pre-write value)
//   int_i                  hardware interrupt lines
//   is_except_i, except_type_i, current_inst_addr_i,
//   is_in_delayslot_i, bad_addr_i   exception decision from M stage
//   status_o..badvaddr_o   register contents
//   timer_int_o            pending timer interrupt
module cp0_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic        is_except_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] A_BADV = 5'd8;
  localparam logic [4:0] A_CNT  = 5'd9;
  localparam logic [4:0] A_CMP  = 5'd11;
  localparam logic [4:0] A_STAT = 5'd12;
  localparam logic [4:0] A_CAUS = 5'd13;
  localparam logic [4:0] A_EPC  = 5'd14;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  iphw_q, iphw_d;
  logic [1:0]  ipsw_q, ipsw_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        tick_q, tick_d;
  logic        tmr_q, tmr_d;

  logic exc, eret, wr;

  always_comb begin
    eret = is_except_i && (except_type_i == 32'he);
    exc  = is_except_i && (except_type_i != 32'he);
    // any exception/ERET squashes the MTC0 in the same cycle
    wr   = we_i && !is_except_i;

    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    ipsw_d = ipsw_q;
    exc_d  = exc_q;
    epc_d  = epc_q;
    badv_d = badv_q;
    cmp_d  = cmp_q;
    tick_d = ~tick_q;
    cnt_d  = tick_q ? cnt_q + 32'd1 : cnt_q;
    iphw_d = {int_i[5] | tmr_q, int_i[4:0]};

    if (wr) begin
      unique case (waddr_i)
        A_CNT:  cnt_d = data_i;
        A_CMP:  cmp_d = data_i;
        A_STAT: begin
          im_d  = data_i[15:8];
          exl_d = data_i[1];
          ie_d  = data_i[0];
        end
        A_CAUS: ipsw_d = data_i[9:8];
        A_EPC:  epc_d = data_i;
        default: ;
      endcase
    end

    if (exc) begin
      exc_d = except_type_i[4:0];
      // nested exceptions keep the original return point
      if (!exl_q) begin
        epc_d = is_in_delayslot_i ?
                current_inst_addr_i - 32'd4 :
                current_inst_addr_i;
        bd_d  = is_in_delayslot_i;
      end
      exl_d = 1'b1;
      if (except_type_i == 32'h4 ||
          except_type_i == 32'h5)
        badv_d = bad_addr_i;
    end

    if (eret)
      exl_d = 1'b0;

`ifdef CP0_TIMER_INT_EN
    tmr_d = tmr_q;
    if (cmp_q != 32'd0 && cnt_q == cmp_q)
      tmr_d = 1'b1;
    if (wr && waddr_i == A_CMP)
      tmr_d = 1'b0;
`else
    tmr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      iphw_q <= '0;
      ipsw_q <= '0;
      exc_q  <= '0;
      epc_q  <= '0;
      badv_q <= '0;
      cnt_q  <= '0;
      cmp_q  <= '0;
      tick_q <= 1'b0;
      tmr_q  <= 1'b0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      iphw_q <= iphw_d;
      ipsw_q <= ipsw_d;
      exc_q  <= exc_d;
      epc_q  <= epc_d;
      badv_q <= badv_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      tick_q <= tick_d;
      tmr_q  <= tmr_d;
    end
  end

  assign status_o = {9'b0, 1'b1, 6'b0, im_q,
                     6'b0, exl_q, ie_q};
  assign cause_o  = {bd_q, 15'b0, iphw_q, ipsw_q,
                     1'b0, exc_q, 2'b0};
  assign epc_o       = epc_q;
  assign count_o     = cnt_q;
  assign compare_o   = cmp_q;
  assign badvaddr_o  = badv_q;
  assign timer_int_o = tmr_q;

  always_comb begin
    unique case (raddr_i)
      A_BADV:  data_o = badv_q;
      A_CNT:   data_o = cnt_q;
      A_CMP:   data_o = cmp_q;
      A_STAT:  data_o = status_o;
      A_CAUS:  data_o = cause_o;
      A_EPC:   data_o = epc_q;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS core. Consumes the memory-stage exception decision (is_except / except_type) and MTC0 writes, and maintains Status, Cause, EPC, BadVAddr, Count and Compare. Supplies MFC0 read data plus the Status/Cause/EPC values that the exception decoder uses for interrupt masking and ERET targets. Sits directly downstream of the exception decoder in the M/W boundary.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- we_i  in  1  MTC0 write enable (memory stage).
- waddr_i  in  5  MTC0 destination register number.
- raddr_i  in  5  MFC0 source register number.
- data_i  in  32  MTC0 write data.
- int_i  in  6  external hardware interrupt lines, level-sensitive.
- is_except_i  in  1  exception/ERET taken this cycle.
- except_type_i  in  32  code from the exception decoder (0x0, 0x4, 0x5, 0x8, 0x9, 0xa, 0xc, 0xe).
- current_inst_addr_i  in  32  PC of the excepting instruction.
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot.
- bad_addr_i  in  32  faulting address for AdEL/AdES.
- data_o  out  32  MFC0 read data.
- status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o  out  32 each  register contents.
- timer_int_o  out  1  pending timer interrupt.

## Operation
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Any other raddr_i reads 0. Writes to other addresses are ignored.
- Reset values: Status 0x0040_0000 (BEV=1), all other registers 0, timer_int_o 0, internal Count tick phase 0.
- Writable fields: Status[15:8] IM, Status[1] EXL, Status[0] IE. Cause[9:8] IP1..0 only. EPC, Count and Compare are fully writable. BadVAddr is read-only to MTC0. All other bits read 0, except Status[22] BEV, which holds 1.
- Cause[15:10] is sampled every cycle from {int_i[5] | timer_int_o, int_i[4:0]}. When the timer is compiled out, Cause[15] is int_i[5] alone.
- Exception handling applies when is_except_i=1 and except_type_i is not 0xe:
  - Cause[6:2] ExcCode <= except_type_i[4:0].
  - If EXL=0: EPC <= current_inst_addr_i - 4 when is_in_delayslot_i=1, else current_inst_addr_i. Cause[31] BD <= is_in_delayslot_i.
  - If EXL=1: EPC and BD are held.
  - EXL <= 1.
  - For type 0x4 or 0x5 only: BadVAddr <= bad_addr_i.
- ERET (is_except_i=1, type 0xe): EXL <= 0. No other register changes.
- Priority: an exception or ERET in a cycle suppresses any MTC0 write in that same cycle.
- Arithmetic: EPC subtraction and the Count increment are modulo 2^32. Count wraps from 0xFFFF_FFFF to 0.

## Timing
- MTC0 writes and exception updates take effect at the next rising edge.
- data_o is combinational from raddr_i and returns the pre-write value. There is no write-to-read bypass; hazards are resolved in the pipeline.
- The Count tick toggles every cycle. Count increments on each cycle where the tick is 1, so Count advances once per 2 clocks.
- An MTC0 to Count loads data_i and overrides that cycle's increment. The tick phase is not reset.
- timer_int_o is set at the edge after Count == Compare while Compare != 0.
- timer_int_o clears at the edge after any MTC0 to Compare. A Compare write wins over a same-cycle match.
- resetn low at any time immediately forces all reset values, including mid-exception.

## Configuration
- CP0_TIMER_INT_EN defined: Count/Compare comparison and timer_int_o are implemented, and timer_int_o is ORed into Cause[15].
- CP0_TIMER_INT_EN undefined: timer_int_o is tied to 0 and no match logic is built. Count still increments, and Compare stays readable and writable.

## Test plan
- Reset: release resetn, then read addr 12 -> 0x0040_0000. Addresses 8, 9, 11, 13 and 14 all read 0.
- Count rate: after reset, wait 10 cycles -> Count=5. MTC0 Count=0xFFFF_FFFF, then 2 cycles later -> Count=0.
- Exception in delay slot: EXL=0, type 0x4, PC 0xBFC0_0100, delayslot=1, bad_addr 0x1003 -> EPC=0xBFC0_00FC, BD=1, ExcCode=4, BadVAddr=0x1003, EXL=1.
- Nested exception: with EXL=1, apply type 0x8 at PC 0x8000_0040 -> EPC is unchanged, ExcCode=8. Then ERET -> EXL=0.
- Priority: in the same cycle, MTC0 EPC=0x1234 and exception type 0xc at PC 0x8000_0000 -> EPC=0x8000_0000.
- Timer (macro on): Compare=20, Count=0 -> timer_int_o=1 when Count reaches 20, and Cause[15]=1. A subsequent MTC0 Compare=100 -> timer_int_o=0 next cycle.
